// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Accepts in IDLE, holds the request in ISSUE until mem_ready or timeout, then answers in RESP.
module mem_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic                  req_wr_rd_0,
  input  logic                  req_wr_rd_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [WIDTH-1:0]      req_wdata_0,
  input  logic [WIDTH-1:0]      req_wdata_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  output logic                  rsp_err_0,
  output logic                  rsp_err_1,
  output logic [WIDTH-1:0]      rsp_rdata_0,
  output logic [WIDTH-1:0]      rsp_rdata_1,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t                state, state_nxt;
  logic                  pri;       // requester that wins a tie
  logic                  gnt;       // requester owning the current transaction
  logic                  lat_wr;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]      lat_wdata;
  logic [WIDTH-1:0]      rdata_q;
  logic                  err_q;
  logic [7:0]            cnt;

  logic accept, win, hs, tmo;

  assign win    = req_valid_1 && (!req_valid_0 || pri);
  assign accept = (state == IDLE) && (req_valid_0 || req_valid_1) && !rst;
  assign hs     = (state == ISSUE) && mem_ready;
  assign tmo    = (state == ISSUE) && !mem_ready && (cnt == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pri       <= 1'b0;
      gnt       <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt       <= win;
        pri       <= ~win;
        lat_wr    <= win ? req_wr_rd_1 : req_wr_rd_0;
        lat_addr  <= win ? req_addr_1  : req_addr_0;
        lat_wdata <= win ? req_wdata_1 : req_wdata_0;
        err_q     <= 1'b0;
        cnt       <= '0;
      end else if (hs) begin
        rdata_q <= lat_wr ? '0 : mem_rdata;
        cnt     <= '0;
      end else if (tmo) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (state == ISSUE) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ISSUE;
      ISSUE:   if (hs || tmo) state_nxt = RESP;
      RESP:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Every output is forced to zero when unqualified so nothing stale leaks out.
  always_comb begin
    req_ready_0 = accept && !win;
    req_ready_1 = accept && win;
    busy        = (state != IDLE);
    mem_valid   = (state == ISSUE);
    mem_wr_rd   = mem_valid && lat_wr;
    mem_addr    = mem_valid ? lat_addr : '0;
    mem_wdata   = (mem_valid && lat_wr) ? lat_wdata : '0;
    rsp_valid_0 = (state == RESP) && !gnt;
    rsp_valid_1 = (state == RESP) && gnt;
    rsp_err_0   = rsp_valid_0 && err_q;
    rsp_err_1   = rsp_valid_1 && err_q;
    rsp_rdata_0 = rsp_valid_0 ? rdata_q : '0;
    rsp_rdata_1 = rsp_valid_1 ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: write, read, contention, wait states, timeout, reset mid-ISSUE.
module tb_mem_arbiter;
  localparam int W = 8, AW = 6;

  logic          clk = 1'b0, rst;
  logic          req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic          req_wr_rd_0, req_wr_rd_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [W-1:0]  req_wdata_0, req_wdata_1;
  logic          rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1;
  logic [W-1:0]  rsp_rdata_0, rsp_rdata_1;
  logic          mem_valid, mem_ready, mem_wr_rd, busy;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;

  int n_chk = 0, n_fail = 0;
  bit rst_done = 1'b0;

  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_wr_rd_0(req_wr_rd_0), .req_wr_rd_1(req_wr_rd_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr_rd(mem_wr_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mutual exclusion of grants and X-freedom, sampled mid-cycle
  always @(negedge clk) if (rst_done) begin
    chk("one_grant", 32'(req_ready_0 && req_ready_1), 32'd0);
    chk("no_x", 32'($isunknown({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
        rsp_err_0, rsp_err_1, rsp_rdata_0, rsp_rdata_1, mem_valid, mem_wr_rd,
        mem_addr, mem_wdata, busy})), 32'd0);
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    req_valid_0 = 0; req_wr_rd_0 = 0; req_addr_0 = '0; req_wdata_0 = '0;
    req_valid_1 = 0; req_wr_rd_1 = 0; req_addr_1 = '0; req_wdata_1 = '0;
    step(); step();
    rst = 1'b0; rst_done = 1'b1; #1;
    chk("rst_outs", {rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1, mem_valid, busy,
                     mem_addr, mem_wdata}, 32'd0);

    // single write from requester 0
    req_valid_0 = 1; req_wr_rd_0 = 1; req_addr_0 = 6'h05; req_wdata_0 = 8'hA5; mem_ready = 1;
    #1;
    chk("wr_ready", {req_ready_1, req_ready_0}, 32'b01);
    step(); req_valid_0 = 0; #1;
    chk("wr_mem", {mem_valid, mem_wr_rd, 2'b0, mem_addr, mem_wdata}, {2'b11, 2'b0, 6'h05, 8'hA5});
    chk("wr_busy", busy, 1);
    step();
    chk("wr_rsp", {rsp_valid_1, rsp_valid_0, rsp_err_0, rsp_rdata_0}, {3'b010, 8'h00});
    chk("wr_rsp_memoff", {mem_valid, mem_addr, mem_wdata}, 32'd0);
    step();
    chk("wr_idle", {busy, rsp_valid_0}, 32'd0);

    // single read from requester 1
    req_valid_1 = 1; req_wr_rd_1 = 0; req_addr_1 = 6'h3F; req_wdata_1 = 8'h77; mem_rdata = 8'h5C;
    #1;
    chk("rd_ready", {req_ready_1, req_ready_0}, 32'b10);
    chk("rd_wdata_idle", mem_wdata, 0);
    step(); req_valid_1 = 0; #1;
    chk("rd_mem", {mem_valid, mem_wr_rd, mem_addr, mem_wdata}, {2'b10, 6'h3F, 8'h00});
    step();
    chk("rd_rsp", {rsp_valid_0, rsp_valid_1, rsp_err_1, rsp_rdata_1}, {3'b010, 8'h5C});
    chk("rd_rsp0_zero", rsp_rdata_0, 0);
    step();

    // contention after a fresh reset: 0,1,0,1
    rst = 1; step(); rst = 0;
    req_valid_0 = 1; req_wr_rd_0 = 0; req_addr_0 = 6'h0A;
    req_valid_1 = 1; req_wr_rd_1 = 0; req_addr_1 = 6'h0B; mem_rdata = 8'h11;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk($sformatf("cont_gnt%0d", t), {req_ready_1, req_ready_0}, (t % 2) ? 32'b10 : 32'b01);
      step();
      chk($sformatf("cont_addr%0d", t), mem_addr, (t % 2) ? 6'h0B : 6'h0A);
      chk($sformatf("cont_noready%0d", t), {req_ready_1, req_ready_0}, 0);
      step();
      chk($sformatf("cont_rsp%0d", t), {rsp_valid_1, rsp_valid_0}, (t % 2) ? 32'b10 : 32'b01);
      step();
    end
    req_valid_0 = 0; req_valid_1 = 0;

    // wait states: 3 low cycles then ready; last grant was 1, so 0 wins
    req_valid_0 = 1; req_wr_rd_0 = 1; req_addr_0 = 6'h12; req_wdata_0 = 8'h3C; mem_ready = 0;
    #1;
    chk("ws_ready", req_ready_0, 1);
    step(); req_valid_0 = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      chk($sformatf("ws_hold%0d", i), {mem_valid, mem_wr_rd, mem_addr, mem_wdata},
          {2'b11, 6'h12, 8'h3C});
      chk($sformatf("ws_norsp%0d", i), rsp_valid_0, 0);
      step();
    end
    chk("ws_rsp", {rsp_valid_0, rsp_err_0, rsp_rdata_0}, {2'b10, 8'h00});
    step(); mem_ready = 0;

    // timeout on a read from requester 1: 16 ISSUE cycles (counter 0..15), then error response
    req_valid_1 = 1; req_wr_rd_1 = 0; req_addr_1 = 6'h20; mem_rdata = 8'hFF;
    #1;
    chk("to_ready", req_ready_1, 1);
    step(); req_valid_1 = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 0 || i == 14 || i == 15) chk($sformatf("to_issue%0d", i), {mem_valid, mem_addr}, {1'b1, 6'h20});
      step();
    end
    chk("to_memdrop", mem_valid, 0);
    chk("to_rsp", {rsp_valid_0, rsp_valid_1, rsp_err_1, rsp_rdata_1}, {3'b011, 8'h00});
    step();
    chk("to_idle", {busy, rsp_valid_1, rsp_err_1}, 0);

    // reset in second ISSUE cycle; requester 0 just won so 1 would be next without reset
    req_valid_0 = 1; req_wr_rd_0 = 1; req_addr_0 = 6'h2A; req_wdata_0 = 8'h99;
    #1;
    chk("rs_ready", req_ready_0, 1);
    step(); req_valid_0 = 0;
    chk("rs_issue1", mem_valid, 1);
    step(); rst = 1; #1;
    chk("rs_issue2", mem_valid, 1);
    step(); rst = 0; #1;
    chk("rs_outs", {rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1, req_ready_0, req_ready_1,
                    mem_valid, mem_wr_rd, busy, mem_addr, mem_wdata}, 32'd0);
    chk("rs_rdata", {rsp_rdata_0, rsp_rdata_1}, 0);
    step();
    chk("rs_norsp", {rsp_valid_0, rsp_valid_1, busy}, 0);
    req_valid_0 = 1; req_valid_1 = 1; #1;
    chk("rs_pri0", {req_ready_1, req_ready_0}, 32'b01);
    step(); req_valid_0 = 0; req_valid_1 = 0;
    step(); step();

    rst_done = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
